// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// Latches two W-bit operands on start and feeds them LSB-first through one
// fullAdder cell, one bit per clock, with a registered carry. The W-bit sum
// and the carry-out are presented together with a one-cycle done pulse.
// Optional feature macro: SERIAL_SUB_EN adds a sub input that turns the
// operation into A-B (two's complement, cout=1 means no borrow).
//
// Handshake: start is a request sampled only while idle (busy=0). Requests
// seen while busy are dropped, not queued. done is a single-cycle strobe and
// sum/cout are valid from that cycle until the next done.

// One-bit full adder cell.
module fullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
`ifdef SERIAL_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic [1:0]   dbg_state
);
    localparam int CW = $clog2(W);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Index of the final (MSB) bit position within an operation.
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [1:0]    r_state;
    logic [W-1:0]  r_a_sh;
    logic [W-1:0]  r_b_sh;
    logic [W-1:0]  r_s_sh;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_sum;
    logic          r_cout;

    logic          w_s;
    logic          w_cout;
    logic [W-1:0]  w_s_next;

    fullAdder u_fa (
        .A    (r_a_sh[0]),
        .B    (r_b_sh[0]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    // New sum bit enters at the top so after W shifts bit 0 holds the LSB.
    assign w_s_next = {w_s, r_s_sh[W-1:1]};

    // Sequencer: latch operands, shift W bits through the cell, publish result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh <= a_in;
`ifdef SERIAL_SUB_EN
                        // A-B computed as A + ~B + 1.
                        r_b_sh  <= sub ? ~b_in : b_in;
                        r_carry <= sub;
`else
                        r_b_sh  <= b_in;
                        r_carry <= 1'b0;
`endif
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_s_sh  <= w_s_next;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_cout;
                    if (r_cnt == CNT_LAST) begin
                        // Only complete results reach sum/cout.
                        r_sum   <= w_s_next;
                        r_cout  <= w_cout;
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == SHIFT) || (r_state == DONE);
    assign done      = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (W=4). Directed steps plus random operands,
// with expected results taken from plain integer arithmetic.
module tb_serial_add_ctrl;
    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    // Model of the published result registers.
    logic [W-1:0] m_sum;
    logic         m_cout;

    serial_add_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
`ifdef SERIAL_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .dbg_state (dbg_state)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: integer add or subtract, split into sum and cout.
    task automatic model(input int a, input int b, input logic s,
                         output logic [W-1:0] es, output logic ec);
        int t;
        if (s) begin
            t  = a - b;
            es = W'(t & MASK);
            ec = (a >= b);
        end else begin
            t  = a + b;
            es = W'(t & MASK);
            ec = t[W];
        end
    endtask

    // One full operation with cycle-exact checks. Inputs are applied on the
    // falling edge; outputs are checked on falling edges.
    task automatic run_op(input string tag, input int a, input int b, input logic s,
                          input logic hold, input int mid_a, input int mid_b);
        logic [W-1:0] es;
        logic         ec;
        model(a, b, s, es, ec);
        @(negedge clk);
        start = 1'b1; a_in = W'(a); b_in = W'(b); sub = s;
        @(negedge clk);                       // accepted on the edge just passed
        if (!hold) start = 1'b0;
        a_in = W'(mid_a); b_in = W'(mid_b); sub = ~s;
        chk({tag, ".busy0"}, 32'(busy), 32'd1);
        chk({tag, ".done0"}, 32'(done), 32'd0);
        for (int k = 1; k < W; k++) begin
            @(negedge clk);
            chk({tag, ".shift_done"}, 32'(done), 32'd0);
            chk({tag, ".shift_busy"}, 32'(busy), 32'd1);
            chk({tag, ".held_sum"}, 32'(sum), 32'(m_sum));
            chk({tag, ".held_cout"}, 32'(cout), 32'(m_cout));
        end
        @(negedge clk);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".done_busy"}, 32'(busy), 32'd1);
        chk({tag, ".sum"}, 32'(sum), 32'(es));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        m_sum = es; m_cout = ec;
        @(negedge clk);
        chk({tag, ".idle_done"}, 32'(done), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ".keep_sum"}, 32'(sum), 32'(m_sum));
    endtask

    initial begin
        int ra, rb;
        logic [W-1:0] es;
        logic ec;
        bit seen;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; sub = 1'b0;
        m_sum = '0; m_cout = 1'b0;

        // 1. Reset for two cycles.
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
        rst = 1'b0;

        // 2-3. Directed additions.
        run_op("add3_5", 3, 5, 1'b0, 1'b0, 0, 0);
        run_op("add15_1", 15, 1, 1'b0, 1'b0, 9, 9);
        run_op("add15_15", 15, 15, 1'b0, 1'b0, 3, 3);

        // 4. start held through the op, operands changed mid-SHIFT.
        run_op("hold2_2", 2, 2, 1'b0, 1'b1, 7, 7);
        // run_op's last check saw busy=0 in the cycle after done; start is
        // still high so the 7+7 request is accepted on the next edge.
        @(negedge clk);
        chk("hold.second_busy", 32'(busy), 32'd1);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < W + 3 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("hold.second_done_seen", 32'(seen), 32'd1);
        model(7, 7, 1'b0, es, ec);
        chk("hold.second_sum", 32'(sum), 32'(es));
        chk("hold.second_cout", 32'(cout), 32'(ec));
        m_sum = es; m_cout = ec;
        @(negedge clk);

        // 5. Reset on the second SHIFT cycle aborts the op.
        start = 1'b1; a_in = 4'd9; b_in = 4'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.sum", 32'(sum), 32'd0);
        chk("abort.cout", 32'(cout), 32'd0);
        m_sum = '0; m_cout = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            chk("abort.no_done", 32'(done), 32'd0);
        end
        run_op("after_abort1_1", 1, 1, 1'b0, 1'b0, 6, 6);

        // rst and start together: rst wins.
        rst = 1'b1; start = 1'b1; a_in = 4'd4; b_in = 4'd4;
        @(negedge clk);
        chk("rst_start.busy", 32'(busy), 32'd0);
        chk("rst_start.sum", 32'(sum), 32'd0);
        m_sum = '0; m_cout = 1'b0;
        rst = 1'b0; start = 1'b0;

        // Random operands.
        for (int n = 0; n < 20; n++) begin
            ra = int'($urandom_range(0, MASK));
            rb = int'($urandom_range(0, MASK));
            run_op("rand_add", ra, rb, 1'b0, 1'b0,
                   int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
        end

`ifdef SERIAL_SUB_EN
        // 6. Subtraction.
        run_op("sub5_3", 5, 3, 1'b1, 1'b0, 0, 0);
        run_op("sub3_5", 3, 5, 1'b1, 1'b0, 0, 0);
        for (int n = 0; n < 10; n++) begin
            ra = int'($urandom_range(0, MASK));
            rb = int'($urandom_range(0, MASK));
            run_op("rand_sub", ra, rb, 1'b1, 1'b0, ra, rb);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
